// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit; the op codes are also the ALU decoder's targets.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One iteration of the shared datapath: add-shift for multiply, trial-subtract-shift for divide.
module muldiv_core_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH:0]   i_work,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH:0]   o_work
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH:0] w_sh;

  // Divide keeps the remainder below the divisor, so bit WIDTH of the trial is a clean borrow.
  always_comb begin
    o_work  = i_work;
    w_sum   = '0;
    w_trial = '0;
    w_sh    = '0;
    if (i_is_div) begin
      w_sh    = {i_work[2*WIDTH-1:0], 1'b0};
      w_trial = w_sh[2*WIDTH:WIDTH] - {1'b0, i_opnd};
      if (!w_trial[WIDTH]) begin
        o_work = {w_trial, w_sh[WIDTH-1:1], 1'b1};
      end else begin
        o_work = {w_sh[2*WIDTH:WIDTH], w_sh[WIDTH-1:1], 1'b0};
      end
    end else begin
      w_sum = i_work[2*WIDTH:WIDTH];
      if (i_work[0]) begin
        w_sum = w_sum + {1'b0, i_opnd};
      end
      o_work = {1'b0, w_sum, i_work[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with start/valid/ack handshake, flush and divide-by-zero flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned WK_W  = 2 * WIDTH + 1;

  md_state_e          r_state;
  md_state_e          w_next;
  logic               w_accept;
  logic               w_last;
  logic               r_is_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_opnd;
  logic [WK_W-1:0]    r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_valid;
  logic               r_dbz;

  logic               w_in_div;
  logic               w_in_sgn;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WK_W-1:0]    w_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_in_div = md_is_div(md_op_e'(op_i));
  assign w_in_sgn = md_is_signed(md_op_e'(op_i));
  assign w_abs_a  = (w_in_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_abs_b  = (w_in_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  assign w_prod   = (2*WIDTH)'(r_opnd) * (2*WIDTH)'(r_work[WIDTH-1:0]);

  muldiv_core_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_work   (r_work),
    .i_opnd   (r_opnd),
    .o_work   (w_step)
  );

  // Next-state logic; cancel overrides everything, ack only matters in DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    unique case (r_state)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          w_accept = 1'b1;
          if (!w_in_div)          w_next = ST_MUL;
          else if (b_i == '0)     w_next = ST_DONE;
          else                    w_next = ST_DIV;
        end
      end
      ST_MUL:  if (FAST_MUL || w_last) w_next = ST_FIX;
      ST_DIV:  if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: if (ack_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (cancel_i) begin
      w_next = ST_IDLE;
    end
  end

  // Sign correction applied in FIX on the magnitude result.
  always_comb begin
    w_prod_fix = r_work[2*WIDTH-1:0];
    w_quo_fix  = r_work[WIDTH-1:0];
    w_rem_fix  = WIDTH'(r_work[2*WIDTH:WIDTH]);
    if (r_sa ^ r_sb) begin
      w_prod_fix = -r_work[2*WIDTH-1:0];
      w_quo_fix  = -r_work[WIDTH-1:0];
    end
    if (r_sa) begin
      w_rem_fix = WIDTH'(-r_work[2*WIDTH:WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_opnd   <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_valid <= (w_next == ST_DONE);
      if (cancel_i) begin
        r_dbz <= 1'b0;
      end else if (w_accept) begin
        r_is_div <= w_in_div;
        r_sa     <= w_in_sgn && a_i[WIDTH-1];
        r_sb     <= w_in_sgn && b_i[WIDTH-1];
        r_cnt    <= '0;
        r_dbz    <= 1'b0;
        if (w_in_div) begin
          r_opnd <= w_abs_b;
          r_work <= {(WIDTH+1)'(0), w_abs_a};
          if (b_i == '0) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b1;
          end
        end else begin
          r_opnd <= w_abs_a;
          r_work <= {(WIDTH+1)'(0), w_abs_b};
        end
      end else begin
        unique case (r_state)
          ST_MUL, ST_DIV: begin
            if (FAST_MUL && r_state == ST_MUL) r_work <= {1'b0, w_prod};
            else                               r_work <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          ST_FIX: begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
          ST_DONE: if (ack_i) r_dbz <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign busy_o        = r_busy;
  assign valid_o       = r_valid;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: iterative and FAST_MUL instances with directed vectors.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_i, cancel_i, ack_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, valid_o, dbz_o;
  logic [W-1:0] hi_o, lo_o;

  logic         f_start, f_cancel, f_ack;
  logic [1:0]   f_op;
  logic [W-1:0] f_a, f_b;
  logic         f_busy, f_valid, f_dbz;
  logic [W-1:0] f_hi, f_lo;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .ack_i(ack_i), .busy_o(busy_o), .valid_o(valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(dbz_o)
  );

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_fast (
    .clk(clk), .rst(rst), .start_i(f_start), .op_i(f_op), .a_i(f_a), .b_i(f_b),
    .cancel_i(f_cancel), .ack_i(f_ack), .busy_o(f_busy), .valid_o(f_valid),
    .hi_o(f_hi), .lo_o(f_lo), .div_by_zero_o(f_dbz)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare each new result against the oldest queued expectation.
  logic pv0 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valid_o && !pv0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got hi=%h lo=%h with no result expected", hi_o, lo_o);
      end else begin
        e = q0.pop_front();
        check("result_hi", hi_o, e.hi);
        check("result_lo", lo_o, e.lo);
        check("result_dbz", W'(dbz_o), W'(e.dbz));
      end
    end
    pv0 = valid_o;
  end

  logic pv1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (f_valid && !pv1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fast_unexpected_valid: got hi=%h lo=%h with no result expected", f_hi, f_lo);
      end else begin
        e = q1.pop_front();
        check("fast_hi", f_hi, e.hi);
        check("fast_lo", f_lo, e.lo);
        check("fast_dbz", W'(f_dbz), W'(e.dbz));
      end
    end
    pv1 = f_valid;
  end

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input logic dbz_e,
                       input int lat_e, input int hold);
    int lat;
    q0.push_back('{hi_e, lo_e, dbz_e});
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), W'(lat_e));
    for (int i = 0; i < hold; i++) begin
      start_i = i[0]; op_i = MD_MULTU; a_i = 3; b_i = 3;
      @(posedge clk); #1;
      check("hold_hi", hi_o, hi_e);
      check("hold_lo", lo_o, lo_e);
      check("hold_valid", W'(valid_o), W'(1));
    end
    start_i = 1'b0;
    ack_i   = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    check("valid_after_ack", W'(valid_o), W'(0));
    check("busy_after_ack", W'(busy_o), W'(0));
    @(posedge clk); #1;
    check("idle_after_ack", W'(busy_o), W'(0));
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    start_i = 1'b0; cancel_i = 1'b0; ack_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    f_start = 1'b0; f_cancel = 1'b0; f_ack = 1'b0; f_op = '0; f_a = '0; f_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy_o), W'(0));
    check("rst_valid", W'(valid_o), W'(0));
    check("rst_hi", hi_o, W'(0));
    check("rst_lo", lo_o, W'(0));
    check("rst_dbz", W'(dbz_o), W'(0));
    rst = 1'b1;

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0);
    do_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 0);
    do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
    do_op(MD_DIVU,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34, 0);
    do_op(MD_DIVU,  32'd5,         32'd0,         32'h0,         32'h0,         1'b1, 1,  0);
    do_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 0);
    do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34, 0);
    do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 0);

    // Flush a divide at T+10; the held result must survive.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = MD_DIV; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    check("cancel_busy", W'(busy_o), W'(0));
    check("cancel_valid", W'(valid_o), W'(0));
    check("cancel_hi", hi_o, 32'h0000_0000);
    check("cancel_lo", lo_o, 32'h8000_0000);
    do_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0);

    do_op(MD_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 1'b0, 34, 5);

    // Cancel and start together in IDLE: the start is dropped.
    @(posedge clk); #1;
    start_i = 1'b1; cancel_i = 1'b1; op_i = MD_MULT; a_i = 32'd2; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    check("start_cancel_busy", W'(busy_o), W'(0));

    // FAST_MUL instance: same signed multiply, result at T+3.
    q1.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    @(posedge clk); #1;
    f_start = 1'b1; f_op = MD_MULT; f_a = 32'hFFFF_FFFD; f_b = 32'd7;
    @(posedge clk); #1;
    f_start = 1'b0;
    lat = 1;
    while (!f_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("fast_latency", W'(lat), W'(3));
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
    check("fast_busy_after_ack", W'(f_busy), W'(0));

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = MD_DIV; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", W'(busy_o), W'(0));
    check("async_rst_valid", W'(valid_o), W'(0));
    check("async_rst_hi", hi_o, W'(0));
    check("async_rst_lo", lo_o, W'(0));
    check("async_rst_dbz", W'(dbz_o), W'(0));
    #3;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", W'(busy_o), W'(0));

    check("q0_drained", W'(q0.size()), W'(0));
    check("q1_drained", W'(q1.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
